// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage: widths, opcode encodings,
// opcode-class decode, buffered-entry layout and condition-code helper.
package writeback_pkg;

    localparam int REG_WIDTH     = 16;
    localparam int VREG_WIDTH    = 64;
    localparam int VREG_ID_WIDTH = 4;
    localparam int PC_WIDTH      = 16;
    localparam int OPCODE_WIDTH  = 8;

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D     = 8'h00;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD_F     = 8'h01;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D    = 8'h02;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_F    = 8'h03;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND_D     = 8'h04;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D    = 8'h05;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV       = 8'h06;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D    = 8'h07;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_F    = 8'h08;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDB       = 8'h09;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW       = 8'h0A;
    localparam logic [OPCODE_WIDTH-1:0] OP_STB       = 8'h0B;
    localparam logic [OPCODE_WIDTH-1:0] OP_STW       = 8'h0C;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRN       = 8'h0D;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZ       = 8'h0E;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRP       = 8'h0F;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZ      = 8'h10;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNP      = 8'h11;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRZP      = 8'h12;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP     = 8'h13;
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP       = 8'h14;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR       = 8'h15;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSRR      = 8'h16;
    localparam logic [OPCODE_WIDTH-1:0] OP_CMP       = 8'h17;
    localparam logic [OPCODE_WIDTH-1:0] OP_CMPI      = 8'h18;
    localparam logic [OPCODE_WIDTH-1:0] OP_VADD      = 8'h19;
    localparam logic [OPCODE_WIDTH-1:0] OP_VMOV      = 8'h1A;
    localparam logic [OPCODE_WIDTH-1:0] OP_VMOVI     = 8'h1B;
    localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOV  = 8'h1C;
    localparam logic [OPCODE_WIDTH-1:0] OP_VCOMPMOVI = 8'h1D;

    typedef struct packed {
        logic scalar_wr;
        logic vector_wr;
        logic cc_wr;
        logic branch;
    } op_class_t;

    typedef struct packed {
        logic [3:0]               reg_idx;
        logic [VREG_ID_WIDTH-1:0] vreg_idx;
        logic [REG_WIDTH-1:0]     data;
        logic [VREG_WIDTH-1:0]    vec;
        logic [PC_WIDTH-1:0]      target;
        logic                     reg_wen;
        logic                     vreg_wen;
        logic                     cc_wen;
        logic                     pc_en;
    } wb_entry_t;

    localparam int ENTRY_WIDTH = $bits(wb_entry_t);

    function automatic op_class_t op_class(input logic [OPCODE_WIDTH-1:0] op);
        op_class_t c;
        c = '0;
        case (op)
            OP_ADD_D, OP_ADD_F, OP_ADDI_D, OP_ADDI_F, OP_AND_D, OP_ANDI_D,
            OP_MOV, OP_MOVI_D, OP_MOVI_F, OP_LDB, OP_LDW: begin
                c.scalar_wr = 1'b1;
                c.cc_wr     = 1'b1;
            end
            OP_JSR, OP_JSRR: begin
                c.scalar_wr = 1'b1;
                c.branch    = 1'b1;
            end
            OP_BRN, OP_BRZ, OP_BRP, OP_BRNZ, OP_BRNP, OP_BRZP, OP_BRNZP, OP_JMP:
                c.branch = 1'b1;
            OP_CMP, OP_CMPI:
                c.cc_wr = 1'b1;
            OP_VADD, OP_VMOV, OP_VMOVI, OP_VCOMPMOV, OP_VCOMPMOVI:
                c.vector_wr = 1'b1;
            default:
                c = '0;
        endcase
        return c;
    endfunction

    // {N,Z,P}: exactly one bit set for any value.
    function automatic logic [2:0] cc_of(input logic [REG_WIDTH-1:0] d);
        logic n;
        logic z;
        n = d[REG_WIDTH-1];
        z = (d == {REG_WIDTH{1'b0}});
        return {n, z, ~n & ~z};
    endfunction

endpackage

// File: rtl/writeback_if.sv
// Memory-stage to writeback bus plus writeback results toward decode/fetch.
interface writeback_if;
    import writeback_pkg::*;

    logic                     I_LOCK;
    logic                     I_MW_Valid;
    logic [PC_WIDTH-1:0]      I_PC;
    logic [OPCODE_WIDTH-1:0]  I_Opcode;
    logic [3:0]               I_DestRegIdx;
    logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx;
    logic [REG_WIDTH-1:0]     I_ALUOut;
    logic [REG_WIDTH-1:0]     I_MemOut;
    logic [VREG_WIDTH-1:0]    I_VecResult;
    logic                     I_BranchTaken;
    logic [PC_WIDTH-1:0]      I_BranchTarget;
    logic                     I_GPUStallSignal;

    logic                     O_LOCK;
    logic [3:0]               O_WriteBackRegIdx;
    logic [VREG_ID_WIDTH-1:0] O_WriteBackVRegIdx;
    logic [REG_WIDTH-1:0]     O_WriteBackData;
    logic [VREG_WIDTH-1:0]    O_VecDestValue;
    logic                     O_RegWEn;
    logic                     O_VRegWEn;
    logic                     O_CCWEn;
    logic [2:0]               O_CCValue;
    logic [PC_WIDTH-1:0]      O_WriteBackPC;
    logic                     O_WriteBackPCEn;
    logic                     O_WBFull;
    logic [15:0]              O_RetireCount;

    modport master (
        output I_LOCK, I_MW_Valid, I_PC, I_Opcode, I_DestRegIdx, I_DestVRegIdx,
               I_ALUOut, I_MemOut, I_VecResult, I_BranchTaken, I_BranchTarget,
               I_GPUStallSignal,
        input  O_LOCK, O_WriteBackRegIdx, O_WriteBackVRegIdx, O_WriteBackData,
               O_VecDestValue, O_RegWEn, O_VRegWEn, O_CCWEn, O_CCValue,
               O_WriteBackPC, O_WriteBackPCEn, O_WBFull, O_RetireCount
    );

    modport slave (
        input  I_LOCK, I_MW_Valid, I_PC, I_Opcode, I_DestRegIdx, I_DestVRegIdx,
               I_ALUOut, I_MemOut, I_VecResult, I_BranchTaken, I_BranchTarget,
               I_GPUStallSignal,
        output O_LOCK, O_WriteBackRegIdx, O_WriteBackVRegIdx, O_WriteBackData,
               O_VecDestValue, O_RegWEn, O_VRegWEn, O_CCWEn, O_CCValue,
               O_WriteBackPC, O_WriteBackPCEn, O_WBFull, O_RetireCount
    );
endinterface

// File: rtl/writeback_fifo2.sv
// Two-entry in-order FIFO; the caller never pushes when full without popping
// and never pops when empty.
module wb_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // State registers; reset discards any buffered entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/writeback.sv
// Writeback stage: buffers retiring instructions in a 2-entry FIFO and emits
// registered register-file, CC and fetch-redirect writes, one per pop.
module writeback
    import writeback_pkg::*;
(
    input  logic        I_CLOCK,
    input  logic        I_RESET,
    writeback_if.slave  wb
);

    typedef struct packed {
        logic                     lock;
        logic [3:0]               reg_idx;
        logic [VREG_ID_WIDTH-1:0] vreg_idx;
        logic [REG_WIDTH-1:0]     data;
        logic [VREG_WIDTH-1:0]    vec;
        logic                     reg_wen;
        logic                     vreg_wen;
        logic                     cc_wen;
        logic [2:0]               cc;
        logic [PC_WIDTH-1:0]      pc;
        logic                     pc_en;
        logic [15:0]              retire;
    } out_t;

    op_class_t  cls_s;
    wb_entry_t  entry_in_s;
    wb_entry_t  entry_out_s;
    logic [1:0] count_s;
    logic       push_s;
    logic       pop_s;
    out_t       out_q, out_d;

    assign pop_s  = wb.I_LOCK & ~wb.I_GPUStallSignal & (count_s != 2'd0);
    assign push_s = wb.I_LOCK & wb.I_MW_Valid & ((count_s != 2'd2) | pop_s);

    // Decode the incoming instruction into its writeback effects.
    always_comb begin
        cls_s               = op_class(wb.I_Opcode);
        entry_in_s          = '0;
        entry_in_s.reg_idx  = wb.I_DestRegIdx;
        entry_in_s.vreg_idx = wb.I_DestVRegIdx;
        entry_in_s.vec      = wb.I_VecResult;
        entry_in_s.target   = wb.I_BranchTarget;
        case (wb.I_Opcode)
            OP_LDB:  entry_in_s.data = {8'h00, wb.I_MemOut[7:0]};
            OP_LDW:  entry_in_s.data = wb.I_MemOut;
            OP_JSR, OP_JSRR: begin
                entry_in_s.data    = wb.I_PC;
                entry_in_s.reg_idx = 4'd7;
            end
            default: entry_in_s.data = wb.I_ALUOut;
        endcase
        entry_in_s.reg_wen  = cls_s.scalar_wr;
        entry_in_s.vreg_wen = cls_s.vector_wr;
        entry_in_s.cc_wen   = cls_s.cc_wr;
        entry_in_s.pc_en    = cls_s.branch & wb.I_BranchTaken;
    end

    wb_fifo2 #(.WIDTH(ENTRY_WIDTH)) u_fifo (
        .clk   (I_CLOCK),
        .rst   (I_RESET),
        .push  (push_s),
        .pop   (pop_s),
        .din   (entry_in_s),
        .dout  (entry_out_s),
        .count (count_s)
    );

    // Strobes pulse only on a pop; the payload holds between pops.
    always_comb begin
        out_d          = out_q;
        out_d.lock     = wb.I_LOCK;
        out_d.reg_wen  = 1'b0;
        out_d.vreg_wen = 1'b0;
        out_d.cc_wen   = 1'b0;
        out_d.pc_en    = 1'b0;
        if (pop_s) begin
            out_d.reg_idx  = entry_out_s.reg_idx;
            out_d.vreg_idx = entry_out_s.vreg_idx;
            out_d.data     = entry_out_s.data;
            out_d.vec      = entry_out_s.vec;
            out_d.pc       = entry_out_s.target;
            out_d.cc       = cc_of(entry_out_s.data);
            out_d.reg_wen  = entry_out_s.reg_wen;
            out_d.vreg_wen = entry_out_s.vreg_wen;
            out_d.cc_wen   = entry_out_s.cc_wen;
            out_d.pc_en    = entry_out_s.pc_en;
            out_d.retire   = out_q.retire + 16'd1;
        end else begin
            out_d.retire = out_q.retire;
        end
    end

    // Output register bank.
    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign wb.O_LOCK             = out_q.lock;
    assign wb.O_WriteBackRegIdx  = out_q.reg_idx;
    assign wb.O_WriteBackVRegIdx = out_q.vreg_idx;
    assign wb.O_WriteBackData    = out_q.data;
    assign wb.O_VecDestValue     = out_q.vec;
    assign wb.O_RegWEn           = out_q.reg_wen;
    assign wb.O_VRegWEn          = out_q.vreg_wen;
    assign wb.O_CCWEn            = out_q.cc_wen;
    assign wb.O_CCValue          = out_q.cc;
    assign wb.O_WriteBackPC      = out_q.pc;
    assign wb.O_WriteBackPCEn    = out_q.pc_en;
    assign wb.O_RetireCount      = out_q.retire;
    assign wb.O_WBFull           = (count_s == 2'd2);

endmodule

// File: tb/tb_writeback.sv
// Directed bench for writeback: vector table per opcode class, then stall,
// lock, mid-stall reset and retire-counter wrap sequences.
module tb_writeback;
    import writeback_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   exp_ret = 0;

    always #5 clk = ~clk;

    writeback_if wb_bus ();

    writeback dut (
        .I_CLOCK (clk),
        .I_RESET (rst),
        .wb      (wb_bus)
    );

    typedef struct {
        logic [7:0]  op;
        logic [15:0] pc;
        logic [3:0]  dest;
        logic [3:0]  vdest;
        logic [15:0] alu;
        logic [15:0] mem;
        logic [63:0] vec;
        logic        taken;
        logic [15:0] tgt;
        logic        e_reg;
        logic        e_vreg;
        logic        e_cc;
        logic        e_pcen;
        logic [3:0]  e_idx;
        logic [15:0] e_data;
        logic [2:0]  e_ccv;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [15:0] pc, input logic [3:0] dest,
                         input logic [3:0] vdest, input logic [15:0] alu, input logic [15:0] mem,
                         input logic [63:0] vec, input logic taken, input logic [15:0] tgt);
        wb_bus.I_Opcode       = op;
        wb_bus.I_PC           = pc;
        wb_bus.I_DestRegIdx   = dest;
        wb_bus.I_DestVRegIdx  = vdest;
        wb_bus.I_ALUOut       = alu;
        wb_bus.I_MemOut       = mem;
        wb_bus.I_VecResult    = vec;
        wb_bus.I_BranchTaken  = taken;
        wb_bus.I_BranchTarget = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_regwen"}, 64'(wb_bus.O_RegWEn), 64'd0);
        chk({name, "_vregwen"}, 64'(wb_bus.O_VRegWEn), 64'd0);
        chk({name, "_ccwen"}, 64'(wb_bus.O_CCWEn), 64'd0);
        chk({name, "_pcen"}, 64'(wb_bus.O_WriteBackPCEn), 64'd0);
    endtask

    task automatic push_alu(input logic [3:0] dest, input logic [15:0] alu);
        drive(OP_ADDI_D, 16'h0000, dest, 4'h0, alu, 16'h0000, 64'h0, 1'b0, 16'h0000);
        wb_bus.I_MW_Valid = 1'b1;
    endtask

    initial begin
        tv[0]  = '{OP_ADDI_D, 16'h0010, 4'd3, 4'd0, 16'h8001, 16'h0000, 64'h0, 1'b0, 16'h0000,
                   1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 16'h8001, 3'b100};
        tv[1]  = '{OP_CMP, 16'h0012, 4'd2, 4'd0, 16'h0000, 16'h0000, 64'h0, 1'b0, 16'h0000,
                   1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 16'h0000, 3'b010};
        tv[2]  = '{OP_JSR, 16'h0040, 4'd1, 4'd0, 16'h5555, 16'h0000, 64'h0, 1'b1, 16'h0100,
                   1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 16'h0040, 3'b001};
        tv[3]  = '{OP_LDB, 16'h0044, 4'd5, 4'd0, 16'h1111, 16'hABCD, 64'h0, 1'b0, 16'h0000,
                   1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 16'h00CD, 3'b001};
        tv[4]  = '{OP_LDW, 16'h0046, 4'd6, 4'd0, 16'h1111, 16'hFFFE, 64'h0, 1'b0, 16'h0000,
                   1'b1, 1'b0, 1'b1, 1'b0, 4'd6, 16'hFFFE, 3'b100};
        tv[5]  = '{OP_AND_D, 16'h0048, 4'd4, 4'd0, 16'h0000, 16'h0000, 64'h0, 1'b0, 16'h0000,
                   1'b1, 1'b0, 1'b1, 1'b0, 4'd4, 16'h0000, 3'b010};
        tv[6]  = '{OP_VADD, 16'h004A, 4'd4, 4'd9, 16'h0005, 16'h0000, 64'h1122334455667788,
                   1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, 16'h0005, 3'b001};
        tv[7]  = '{OP_BRZ, 16'h004C, 4'd0, 4'd0, 16'h0007, 16'h0000, 64'h0, 1'b1, 16'h0200,
                   1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 16'h0007, 3'b001};
        tv[8]  = '{OP_BRN, 16'h004E, 4'd0, 4'd0, 16'h8000, 16'h0000, 64'h0, 1'b0, 16'h0300,
                   1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h8000, 3'b100};
        tv[9]  = '{OP_STW, 16'h0050, 4'd2, 4'd0, 16'h1234, 16'h0000, 64'h0, 1'b0, 16'h0000,
                   1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 16'h1234, 3'b001};
        tv[10] = '{OP_JSRR, 16'h0080, 4'd3, 4'd0, 16'h9999, 16'h0000, 64'h0, 1'b1, 16'h0400,
                   1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 16'h0080, 3'b001};
        tv[11] = '{OP_MOVI_F, 16'h0082, 4'd15, 4'd0, 16'h7FFF, 16'h0000, 64'h0, 1'b0, 16'h0000,
                   1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 16'h7FFF, 3'b001};

        rst = 1'b1;
        wb_bus.I_LOCK = 1'b1;
        wb_bus.I_MW_Valid = 1'b0;
        wb_bus.I_GPUStallSignal = 1'b0;
        drive(8'h00, 16'h0, 4'h0, 4'h0, 16'h0, 16'h0, 64'h0, 1'b0, 16'h0);
        tick();
        tick();
        chk("rst_lock", 64'(wb_bus.O_LOCK), 64'd0);
        chk("rst_cc", 64'(wb_bus.O_CCValue), 64'd0);
        chk("rst_retire", 64'(wb_bus.O_RetireCount), 64'd0);
        chk("rst_full", 64'(wb_bus.O_WBFull), 64'd0);
        chk("rst_data", 64'(wb_bus.O_WriteBackData), 64'd0);
        chk_idle("rst");
        rst = 1'b0;

        // One instruction per pair of cycles: push edge, then pop edge.
        for (int i = 0; i < 12; i++) begin
            drive(tv[i].op, tv[i].pc, tv[i].dest, tv[i].vdest, tv[i].alu, tv[i].mem,
                  tv[i].vec, tv[i].taken, tv[i].tgt);
            wb_bus.I_MW_Valid = 1'b1;
            tick();
            wb_bus.I_MW_Valid = 1'b0;
            chk_idle($sformatf("v%0d_lat", i));
            tick();
            exp_ret++;
            chk($sformatf("v%0d_regwen", i), 64'(wb_bus.O_RegWEn), 64'(tv[i].e_reg));
            chk($sformatf("v%0d_vregwen", i), 64'(wb_bus.O_VRegWEn), 64'(tv[i].e_vreg));
            chk($sformatf("v%0d_ccwen", i), 64'(wb_bus.O_CCWEn), 64'(tv[i].e_cc));
            chk($sformatf("v%0d_pcen", i), 64'(wb_bus.O_WriteBackPCEn), 64'(tv[i].e_pcen));
            chk($sformatf("v%0d_idx", i), 64'(wb_bus.O_WriteBackRegIdx), 64'(tv[i].e_idx));
            chk($sformatf("v%0d_data", i), 64'(wb_bus.O_WriteBackData), 64'(tv[i].e_data));
            chk($sformatf("v%0d_cc", i), 64'(wb_bus.O_CCValue), 64'(tv[i].e_ccv));
            chk($sformatf("v%0d_pc", i), 64'(wb_bus.O_WriteBackPC), 64'(tv[i].tgt));
            chk($sformatf("v%0d_vidx", i), 64'(wb_bus.O_WriteBackVRegIdx), 64'(tv[i].vdest));
            chk($sformatf("v%0d_vec", i), wb_bus.O_VecDestValue, tv[i].vec);
            chk($sformatf("v%0d_retire", i), 64'(wb_bus.O_RetireCount), 64'(exp_ret));
        end

        // Stall with three pushes: third is held until the stall releases.
        wb_bus.I_GPUStallSignal = 1'b1;
        push_alu(4'd1, 16'h0011);
        tick();
        chk("stall_full1", 64'(wb_bus.O_WBFull), 64'd0);
        push_alu(4'd2, 16'h0022);
        tick();
        chk("stall_full2", 64'(wb_bus.O_WBFull), 64'd1);
        push_alu(4'd3, 16'h0033);
        tick();
        chk("stall_full3", 64'(wb_bus.O_WBFull), 64'd1);
        chk_idle("stall_idle");
        wb_bus.I_GPUStallSignal = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick();
            wb_bus.I_MW_Valid = 1'b0;
            exp_ret++;
            chk($sformatf("drain%0d_regwen", k), 64'(wb_bus.O_RegWEn), 64'd1);
            chk($sformatf("drain%0d_idx", k), 64'(wb_bus.O_WriteBackRegIdx), 64'(k));
            chk($sformatf("drain%0d_data", k), 64'(wb_bus.O_WriteBackData), 64'(k * 17));
            chk($sformatf("drain%0d_full", k), 64'(wb_bus.O_WBFull), (k == 1) ? 64'd1 : 64'd0);
        end
        tick();
        chk_idle("drain_end");
        chk("drain_retire", 64'(wb_bus.O_RetireCount), 64'(exp_ret));

        // Lock low: no push, buffered entry frozen, O_LOCK follows one cycle late.
        wb_bus.I_LOCK = 1'b0;
        push_alu(4'd9, 16'h0099);
        tick();
        wb_bus.I_MW_Valid = 1'b0;
        chk("nolock_olock", 64'(wb_bus.O_LOCK), 64'd0);
        tick();
        chk_idle("nolock_push");
        wb_bus.I_LOCK = 1'b1;
        wb_bus.I_GPUStallSignal = 1'b1;
        push_alu(4'd8, 16'h0088);
        tick();
        wb_bus.I_MW_Valid = 1'b0;
        wb_bus.I_LOCK = 1'b0;
        wb_bus.I_GPUStallSignal = 1'b0;
        tick();
        tick();
        chk_idle("frozen");
        chk("frozen_retire", 64'(wb_bus.O_RetireCount), 64'(exp_ret));
        wb_bus.I_LOCK = 1'b1;
        tick();
        exp_ret++;
        chk("unlock_olock", 64'(wb_bus.O_LOCK), 64'd1);
        chk("unlock_regwen", 64'(wb_bus.O_RegWEn), 64'd1);
        chk("unlock_idx", 64'(wb_bus.O_WriteBackRegIdx), 64'd8);
        chk("unlock_data", 64'(wb_bus.O_WriteBackData), 64'h0088);
        chk("unlock_retire", 64'(wb_bus.O_RetireCount), 64'(exp_ret));

        // Asynchronous reset mid-cycle with two entries buffered.
        wb_bus.I_GPUStallSignal = 1'b1;
        push_alu(4'd5, 16'h0055);
        tick();
        push_alu(4'd6, 16'h0066);
        tick();
        wb_bus.I_MW_Valid = 1'b0;
        chk("pre_rst_full", 64'(wb_bus.O_WBFull), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_full", 64'(wb_bus.O_WBFull), 64'd0);
        chk("async_retire", 64'(wb_bus.O_RetireCount), 64'd0);
        chk("async_olock", 64'(wb_bus.O_LOCK), 64'd0);
        chk("async_data", 64'(wb_bus.O_WriteBackData), 64'd0);
        tick();
        rst = 1'b0;
        wb_bus.I_GPUStallSignal = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_idle($sformatf("post_rst%0d", k));
            chk($sformatf("post_rst%0d_full", k), 64'(wb_bus.O_WBFull), 64'd0);
        end
        chk("post_rst_retire", 64'(wb_bus.O_RetireCount), 64'd0);

        // 65535 back-to-back retires, then one more wraps the counter.
        drive(OP_STW, 16'h0, 4'h0, 4'h0, 16'h0, 16'h0, 64'h0, 1'b0, 16'h0);
        wb_bus.I_MW_Valid = 1'b1;
        repeat (65535) @(posedge clk);
        #1;
        wb_bus.I_MW_Valid = 1'b0;
        tick();
        chk("preset_ffff", 64'(wb_bus.O_RetireCount), 64'hFFFF);
        tick();
        chk("hold_ffff", 64'(wb_bus.O_RetireCount), 64'hFFFF);
        wb_bus.I_MW_Valid = 1'b1;
        tick();
        wb_bus.I_MW_Valid = 1'b0;
        tick();
        chk("wrap_0000", 64'(wb_bus.O_RetireCount), 64'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 I_CLOCK  input  1  single clock; all state updates on rising edge.
REQ-002 I_RESET  input  1  asynchronous, active-high reset.
REQ-003 I_LOCK  input  1  pipeline enable; no push, pop or counter update while 0.
REQ-004 I_MW_Valid  input  1  memory stage presents a valid retiring instruction.
REQ-005 I_PC, I_Opcode, I_DestRegIdx[3:0], I_DestVRegIdx  input  `PC_WIDTH/`OPCODE_WIDTH/4/`VREG_ID_WIDTH  instruction identity.
REQ-006 I_ALUOut, I_MemOut  input  `REG_WIDTH each  execute result, load data.
REQ-007 I_VecResult  input  `VREG_WIDTH  vector result.
REQ-008 I_BranchTaken, I_BranchTarget  input  1/`PC_WIDTH  resolved control transfer.
REQ-009 I_GPUStallSignal  input  1  decode/GPU cannot accept writeback this cycle.
REQ-010 O_LOCK  output  1  registered copy of I_LOCK.
REQ-011 O_WriteBackRegIdx[3:0], O_WriteBackVRegIdx, O_WriteBackData, O_VecDestValue  output  scalar/vector writeback payload.
REQ-012 O_RegWEn, O_VRegWEn, O_CCWEn  output  1 each  single-cycle write strobes to the decode register files and CC.
REQ-013 O_CCValue[2:0]  output  {N,Z,P} for the written result.
REQ-014 O_WriteBackPC, O_WriteBackPCEn  output  `PC_WIDTH/1  fetch redirect, single-cycle pulse.
REQ-015 O_WBFull  output  1  holding buffer full; memory stage shall hold.
REQ-016 O_RetireCount  output  16  retired-instruction counter.

Function
REQ-017 Two-entry in-order holding FIFO; push = I_LOCK & I_MW_Valid & (count<2 | pop).
REQ-018 pop = I_LOCK & ~I_GPUStallSignal & count>0; popped entry drives outputs on the next edge (push-to-strobe latency 1 cycle through an empty FIFO, no combinational bypass).
REQ-019 Push and pop in the same cycle with count=2 shall leave count=2 and preserve order; with count=1 leave count=1.
REQ-020 O_WBFull = (count==2), combinational from registered count only.
REQ-021 Data select: OP_LDB/OP_LDW -> I_MemOut (LDB zero-extends bits [7:0]); OP_JSR/OP_JSRR -> I_PC (link, dest forced to 7); else I_ALUOut.
REQ-022 O_RegWEn for ADD_D, ADD_F, ADDI_D, ADDI_F, AND_D, ANDI_D, MOV, MOVI_D, MOVI_F, LDB, LDW, JSR, JSRR; never for branches, stores, CMP, vector ops.
REQ-023 O_VRegWEn for VADD, VMOV, VMOVI, VCOMPMOV, VCOMPMOVI; O_VecDestValue = I_VecResult.
REQ-024 O_CCWEn for all scalar arithmetic/logic/move/load and CMP, CMPI; CC: N=data[15], Z=(data==0), P=~N&~Z; exactly one bit set.
REQ-025 O_WriteBackPCEn for BRx/JMP/JSR/JSRR with I_BranchTaken=1; O_WriteBackPC = I_BranchTarget.
REQ-026 All strobes deasserted in every cycle without a pop; payload outputs hold last value.
REQ-027 O_RetireCount increments by 1 per pop, wraps 0xFFFF -> 0x0000.
REQ-028 I_LOCK=0 freezes FIFO and counter and forces all strobes to 0.

Reset
REQ-029 I_RESET asserted at any time clears count to 0, discards buffered entries, zeroes O_RetireCount and all outputs (O_CCValue=3'b000, O_LOCK=0) immediately.
REQ-030 First push is accepted on the first rising edge after I_RESET deasserts.

Structure
REQ-031 Opcode constants, `REG_WIDTH, `VREG_WIDTH, `VREG_ID_WIDTH, `PC_WIDTH come from global_def.h; opcode-class decode (scalar-write, vector-write, CC-write, branch) is a shared function there.
REQ-032 One sub-module: wb_fifo2 (parameterised-width 2-entry FIFO with count, push, pop).

Verification
REQ-033 ADDI_D R3 result 0x8001, stall=0 -> next cycle RegWEn=1, idx=3, data=0x8001, CCWEn=1, CC=3'b100, retire count 1.
REQ-034 CMP result 0x0000 -> CCWEn=1, CC=3'b010, RegWEn=0.
REQ-035 Stall held 3 cycles with 3 valid pushes -> WBFull=1 after second, third held; release -> entries written back in order, one per cycle.
REQ-036 JSR at PC 0x0040, target 0x0100, taken -> RegWEn idx 7 data 0x0040, PCEn pulse 1 cycle with PC 0x0100.
REQ-037 Counter preset to 0xFFFF by 65535 retires, one more retire -> 0x0000.
REQ-038 Reset asserted mid-stall with 2 buffered -> count 0, WBFull=0, no strobes after release.
